// File: rtl/conv_array_ctrl.sv
// Stage sequencer for the 6-wide convolution kernel array: stage codes, weight/line addresses
// and result-row tracking. Define CONV_CTRL_PERF_CNT_EN to build the busy-cycle counter.
module conv_array_ctrl #(
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned IMAGE_SIZE   = 8,
    parameter int unsigned PIPE_LATENCY = 4,
    parameter int unsigned WADDR_W      = 4,
    parameter int unsigned LADDR_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    output logic [2:0]         current_state,
    output logic [WADDR_W-1:0] o_weight_addr,
    output logic               o_line_rd,
    output logic [LADDR_W-1:0] o_line_addr,
    output logic [LADDR_W-1:0] o_out_row,
    output logic               o_result_valid,
    output logic [LADDR_W-1:0] o_result_row,
    output logic               o_busy,
    output logic               o_done,
    output logic [31:0]        o_cycle_cnt
);

    localparam int unsigned OUT_ROWS = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam logic [WADDR_W-1:0] COL_LAST = WADDR_W'(KERNEL_SIZE - 1);
    localparam logic [LADDR_W-1:0] ROW_LAST = LADDR_W'(OUT_ROWS - 1);

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StPreload = 3'd1,
        StRow0    = 3'd2,
        StRow1    = 3'd3,
        StRow2    = 3'd4,
        StBias    = 3'd5,
        StLoad    = 3'd6,
        StIdle    = 3'd7
    } state_e;

    state_e                  state_q, state_d;
    logic [WADDR_W-1:0]      col_q, col_d;
    logic [LADDR_W-1:0]      row_q, row_d;
    logic [PIPE_LATENCY-1:0] pipe_vld_q;
    logic [LADDR_W-1:0]      pipe_row_q [PIPE_LATENCY];
    logic                    push;
    logic                    busy;
    logic                    start_go;
    logic                    col_last;

    assign col_last = (col_q == COL_LAST);
    assign busy     = (state_q != StIdle) || (|pipe_vld_q);
    assign start_go = (state_q == StIdle) && i_start && !busy && !i_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_go) begin
                    state_d = StInit;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StInit: begin
                state_d = StPreload;
                col_d   = '0;
                row_d   = '0;
            end
            StPreload, StRow0, StRow1, StRow2: begin
                if (col_last) begin
                    col_d = '0;
                    // Stage codes are consecutive from PRELOAD through BIAS
                    state_d = state_e'(state_q + 3'd1);
                end else begin
                    col_d = col_q + WADDR_W'(1);
                end
            end
            StBias: begin
                push    = 1'b1;
                state_d = (row_q < ROW_LAST) ? StLoad : StIdle;
            end
            StLoad: begin
                row_d   = row_q + LADDR_W'(1);
                state_d = StRow0;
            end
            default: state_d = StIdle;
        endcase
        if (i_abort) begin
            state_d = StIdle;
            col_d   = '0;
            row_d   = '0;
            push    = 1'b0;
        end
    end

    // Drain pipe mirrors the array latency from BIAS to a valid pixel bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int unsigned i = 0; i < PIPE_LATENCY; i++) begin
                pipe_row_q[i] <= '0;
            end
        end else if (i_abort) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= push;
            pipe_row_q[0] <= row_q;
            for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_row_q[i] <= pipe_row_q[i-1];
            end
        end
    end

    always_comb begin
        current_state = state_q;
        o_weight_addr = '0;
        o_line_rd     = 1'b0;
        o_line_addr   = '0;
        case (state_q)
            StPreload: begin
                o_line_rd   = 1'b1;
                o_line_addr = LADDR_W'(col_q);
            end
            StRow0:  o_weight_addr = col_q;
            StRow1:  o_weight_addr = WADDR_W'(KERNEL_SIZE) + col_q;
            StRow2:  o_weight_addr = WADDR_W'(2 * KERNEL_SIZE) + col_q;
            StBias:  o_weight_addr = WADDR_W'(KERNEL_SIZE * KERNEL_SIZE);
            StLoad: begin
                o_line_rd   = 1'b1;
                o_line_addr = row_q + LADDR_W'(KERNEL_SIZE);
            end
            default: ;
        endcase
    end

    assign o_out_row      = row_q;
    assign o_result_valid = pipe_vld_q[PIPE_LATENCY-1];
    assign o_result_row   = pipe_vld_q[PIPE_LATENCY-1] ? pipe_row_q[PIPE_LATENCY-1] : '0;
    assign o_done         = pipe_vld_q[PIPE_LATENCY-1] && (pipe_row_q[PIPE_LATENCY-1] == ROW_LAST);
    assign o_busy         = busy;

`ifdef CONV_CTRL_PERF_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (start_go) begin
            cyc_q <= '0;
        end else if (busy && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign o_cycle_cnt = cyc_q;
`else
    assign o_cycle_cnt = '0;
`endif

endmodule
